// File: rtl/mau_pkg.sv
// Shared types and helpers for the load/store front-end (mem_access_unit).
package mau_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_t;

    // Reserved size is treated as misaligned so it shares the error path.
    function automatic logic misaligned(input size_t size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input size_t size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_logic.sv
// Combinational lane steering: little-endian store merge and load extract/extend.
module mau_lane_logic
    import mau_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    function automatic logic [31:0] extend8(input logic signed [7:0] v, input logic sx);
        return sx ? 32'(v) : {24'd0, v};
    endfunction

    function automatic logic [31:0] extend16(input logic signed [15:0] v, input logic sx);
        return sx ? 32'(v) : {16'd0, v};
    endfunction

    logic [31:0] shifted;

    always_comb begin
        merged = old_word;
        case (size_t'(size))
            SZ_B:    merged[{lane, 3'b000} +: 8]        = wdata[7:0];
            SZ_H:    merged[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        case (size_t'(size))
            SZ_B:    load_data = extend8(shifted[7:0], sign_ext);
            SZ_H:    load_data = extend16(shifted[15:0], sign_ext);
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front-end for a word-wide DataMemory; sub-word stores use RMW.
// Optional build macro MAU_BOUNDS_CHECK_EN rejects accesses that run past MEM_BYTES.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

`ifdef MAU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t            state, state_nxt;
    logic              we_p0, signed_p0;
    size_t             size_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;
    logic [31:0]       data_p1;
    logic [31:0]       merged, load_data;
    logic [ADDR_W:0]   end_addr;
    logic              oob, illegal, accept;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);

    // One extra bit so an access ending exactly at 2**ADDR_W cannot wrap.
    assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(size_t'(req_size)));
    assign oob      = end_addr > (ADDR_W+1)'(MEM_BYTES);
    assign illegal  = misaligned(size_t'(req_size), req_addr[1:0]) || (BOUNDS_EN && oob);

    assign mem_addr = {addr_p0[ADDR_W-1:2], 2'b00};

    // Stage p0: request fields latched at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p0     <= 1'b0;
            signed_p0 <= 1'b0;
            size_p0   <= SZ_B;
            addr_p0   <= '0;
            wdata_p0  <= '0;
        end else if (accept) begin
            we_p0     <= req_we;
            signed_p0 <= req_signed;
            size_p0   <= size_t'(req_size);
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
        end
    end

    // Stage p1: data word (raw load word, merged store word, or full store word)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
        end else begin
            case (state)
                IDLE:    if (accept) data_p1 <= req_wdata;
                LOAD:    data_p1 <= mem_rd;
                RMW_RD:  data_p1 <= merged;
                default: ;
            endcase
        end
    end

    mau_lane_logic u_lane (
        .old_word  (mem_rd),
        .wdata     (wdata_p0),
        .rd_word   (data_p1),
        .size      (size_p0),
        .lane      (addr_p0[1:0]),
        .sign_ext  (signed_p0),
        .merged    (merged),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal)                     state_nxt = ERR;
                    else if (!req_we)                state_nxt = LOAD;
                    else if (size_t'(req_size) == SZ_W) state_nxt = WRITE;
                    else                             state_nxt = RMW_RD;
                end
            end
            LOAD:   state_nxt = RESP;
            RMW_RD: state_nxt = WRITE;
            WRITE: begin
                mem_we    = 1'b1;
                mem_wd    = data_p1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = we_p0 ? 32'd0 : load_data;
                state_nxt  = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, directed and random requests.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 262144;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] ram    [0:131071];
    logic [7:0]  mbytes [0:524287];

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_addr[18:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[18:2]] <= mem_wd;

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        ram[a[18:2]] <= w;
        for (int i = 0; i < 4; i++) mbytes[a + i] = w[8*i +: 8];
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic o_err, output logic [31:0] o_rd,
                          output int o_pulses, output logic [31:0] o_weaddr);
        int          nb, exp_lat, lat, t, exp_pulses;
        logic        exp_err, r_err;
        logic [31:0] exp_rd, r_rd, wa, dut_w, mdl_w;
        longint      v;
        bit          busy_ready, unaligned;

        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_err = (sz == 2'b11) || (a % nb != 0);
`ifdef MAU_BOUNDS_CHECK_EN
        if (longint'(a) + nb > MEM_BYTES) exp_err = 1'b1;
`endif
        exp_rd = '0;
        if (!exp_err && !we) begin
            v = 0;
            for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(mbytes[a + i]);
            if (sg && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v = v - (longint'(1) << (8*nb));
            exp_rd = v[31:0];
        end
        exp_lat    = exp_err ? 0 : (!we || nb == 4) ? 1 : 2;
        exp_pulses = (we && !exp_err) ? 1 : 0;

        o_err = 1'bx; o_rd = 'x; o_pulses = 0; o_weaddr = '0;
        t = 0;
        while (req_ready !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_timeout: got %b want 1", tag, req_ready);
            return;
        end

        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat = -1; busy_ready = 0; unaligned = 0; r_err = 1'bx; r_rd = 'x;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (mem_addr[1:0] != 2'b00) unaligned = 1;
            if (mem_we === 1'b1) begin
                o_pulses++;
                o_weaddr = mem_addr;
            end
            if (resp_valid === 1'b1) begin
                lat = k; r_err = resp_err; r_rd = resp_rdata;
                break;
            end
            if (req_ready !== 1'b0) busy_ready = 1;
        end
        o_err = r_err; o_rd = r_rd;

        if (!exp_err && we)
            for (int i = 0; i < nb; i++) mbytes[a + i] = wd[8*i +: 8];

        n_vec++;
        if (lat != exp_lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat); end
        n_vec++;
        if (r_err !== exp_err) begin n_err++; $display("FAIL %s resp_err: got %b want %b", tag, r_err, exp_err); end
        n_vec++;
        if (r_rd !== exp_rd) begin n_err++; $display("FAIL %s resp_rdata: got %h want %h", tag, r_rd, exp_rd); end
        n_vec++;
        if (o_pulses != exp_pulses) begin n_err++; $display("FAIL %s mem_we_pulses: got %0d want %0d", tag, o_pulses, exp_pulses); end
        if (o_pulses == 1) begin
            n_vec++;
            if (o_weaddr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL %s mem_addr: got %h want %h", tag, o_weaddr, {a[31:2], 2'b00}); end
        end
        n_vec++;
        if (busy_ready || unaligned) begin n_err++; $display("FAIL %s busy_ready_or_unaligned: got %b%b want 00", tag, busy_ready, unaligned); end
        wa    = {a[31:2], 2'b00};
        dut_w = ram[wa[18:2]];
        mdl_w = {mbytes[wa + 3], mbytes[wa + 2], mbytes[wa + 1], mbytes[wa]};
        n_vec++;
        if (dut_w !== mdl_w) begin n_err++; $display("FAIL %s mem_word: got %h want %h", tag, dut_w, mdl_w); end
    endtask

    task automatic test_reset();
        logic [31:0] got [7];
        logic [31:0] want [7];
        string       nm [7];
        #12;
        got = '{32'(req_ready), 32'(resp_valid), 32'(resp_err), resp_rdata, 32'(mem_we), mem_addr, mem_wd};
        want = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        nm = '{"req_ready", "resp_valid", "resp_err", "resp_rdata", "mem_we", "mem_addr", "mem_wd"};
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (got[i] !== want[i]) begin n_err++; $display("FAIL reset_%s: got %h want %h", nm[i], got[i], want[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic e; logic [31:0] r, wa; int p;
        do_req("sw0", 1'b1, 2'b10, 1'b0, 32'd0, 32'h0000AFAF, e, r, p, wa);
        n_vec++;
        if (p != 1 || wa !== 32'd0) begin n_err++; $display("FAIL sw0_pulse: got %0d@%h want 1@0", p, wa); end
        do_req("lw0", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, e, r, p, wa);
        n_vec++;
        if (r !== 32'h0000AFAF || e !== 1'b0) begin n_err++; $display("FAIL lw0_data: got %h/%b want 0000afaf/0", r, e); end
    endtask

    task automatic test_byte_rmw();
        logic e; logic [31:0] r, wa; int p;
        preload(32'd10000, 32'hFFFF0000);
        do_req("sb", 1'b1, 2'b00, 1'b0, 32'd10001, 32'h123456AB, e, r, p, wa);
        n_vec++;
        if (ram[2500] !== 32'hFFFFAB00) begin n_err++; $display("FAIL sb_merge: got %h want ffffab00", ram[2500]); end
        do_req("lb_s", 1'b0, 2'b00, 1'b1, 32'd10001, 32'd0, e, r, p, wa);
        n_vec++;
        if (r !== 32'hFFFFFFAB) begin n_err++; $display("FAIL lb_signed: got %h want ffffffab", r); end
        do_req("lb_u", 1'b0, 2'b00, 1'b0, 32'd10001, 32'd0, e, r, p, wa);
        n_vec++;
        if (r !== 32'h000000AB) begin n_err++; $display("FAIL lb_unsigned: got %h want 000000ab", r); end
    endtask

    task automatic test_half();
        logic e; logic [31:0] r, wa; int p;
        preload(32'd152100, 32'hABCDEFAA);
        do_req("lh_s", 1'b0, 2'b01, 1'b1, 32'd152102, 32'd0, e, r, p, wa);
        n_vec++;
        if (r !== 32'hFFFFABCD) begin n_err++; $display("FAIL lh_signed: got %h want ffffabcd", r); end
        do_req("lh_u", 1'b0, 2'b01, 1'b0, 32'd152100, 32'd0, e, r, p, wa);
        n_vec++;
        if (r !== 32'h0000EFAA) begin n_err++; $display("FAIL lh_unsigned: got %h want 0000efaa", r); end
    endtask

    task automatic test_illegal();
        logic e; logic [31:0] r, wa; int p;
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'd2, 32'd1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            do_req("illegal", 1'(i == 2), sz[i], 1'b0, ad[i], 32'hCAFEF00D, e, r, p, wa);
            n_vec++;
            if (e !== 1'b1 || r !== 32'd0 || p != 0) begin
                n_err++;
                $display("FAIL illegal_%0d: got err=%b rd=%h we=%0d want 1/0/0", i, e, r, p);
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic e; logic [31:0] r, wa; int p;
        int t;
        preload(32'd0, 32'h11223344);
        t = 0;
        while (req_ready !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'h000000AB;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got req_ready=%b want 0", req_ready); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
            n_err++;
            $display("FAIL rmw_async_reset: got rdy=%b rv=%b we=%b addr=%h wd=%h want 1/0/0/0/0",
                     req_ready, resp_valid, mem_we, mem_addr, mem_wd);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (ram[0] !== 32'h11223344) begin n_err++; $display("FAIL rmw_abandoned: got %h want 11223344", ram[0]); end
        do_req("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, e, r, p, wa);
    endtask

    task automatic test_bounds();
        logic e; logic [31:0] r, wa; int p;
        do_req("bounds", 1'b1, 2'b10, 1'b0, 32'd262144, 32'hDEADBEEF, e, r, p, wa);
`ifdef MAU_BOUNDS_CHECK_EN
        n_vec++;
        if (e !== 1'b1 || p != 0) begin n_err++; $display("FAIL bounds_reject: got err=%b we=%0d want 1/0", e, p); end
`else
        n_vec++;
        if (p != 1 || wa !== 32'd262144) begin n_err++; $display("FAIL bounds_pass: got we=%0d@%h want 1@00040000", p, wa); end
`endif
    endtask

    task automatic test_random();
        logic e; logic [31:0] r, wa, a; int p;
        logic [1:0] sz;
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 3) == 0) ? 32'(262136 + $urandom_range(0, 15)) : 32'($urandom_range(0, 63));
            do_req("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, e, r, p, wa);
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) ram[i] <= '0;
        for (int i = 0; i < 524288; i++) mbytes[i] = '0;
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_illegal();
        test_reset_mid_rmw();
        test_bounds();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the CPU memory stage and DataMemory (clk, we, addr, wd, rd; 32-bit word RAM, combinational read, write on rising clk when we=1).
- Accepts byte/half/word load and store requests over a valid/ready handshake.
- Sub-word stores are performed as read-modify-write on the word RAM.
- Returns sign/zero-extended load data and an error flag for misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, request and memory address width (byte address).
- MEM_BYTES, 262144, DataMemory size in bytes; used only by the bounds check.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; access rejected.
- resp_rdata  out  32  load result, valid with resp_valid (0 for stores and errors).
- mem_we  out  1  to DataMemory we.
- mem_addr  out  ADDR_W  to DataMemory addr; always word-aligned (bits [1:0] = 0).
- mem_wd  out  32  to DataMemory wd.
- mem_rd  in  32  from DataMemory rd.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wd=0; all latched request fields cleared.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on a rising edge with req_valid&req_ready; all request fields are latched at that edge.
  - Responses have no backpressure.
- Byte order is little-endian: lane = addr[1:0], lane 0 = bits [7:0].
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned access or size 11 -> error path.
- FSM states and transitions:
  - IDLE: on accept -> ERR if the request is illegal; LOAD for a load; WRITE for a word store; RMW_RD for a sub-word store.
  - LOAD: mem_addr = {addr[31:2],2'b00}; mem_rd is captured at the edge; -> RESP.
  - RMW_RD: same address; mem_rd is captured into the merge register; -> WRITE.
  - WRITE: mem_we=1 for exactly this cycle; mem_wd = merged word (word store: req_wdata); -> RESP.
  - RESP: resp_valid=1, resp_err=0, resp_rdata = extracted/extended load data; -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0; no memory write; -> IDLE.
- Latency (accept at edge N):
  - Load or word store: resp_valid high in the cycle after edge N+1.
  - Sub-word store: resp_valid high after edge N+2.
  - Error: resp_valid high after edge N.
  - Next accept is possible on the edge that ends RESP/ERR.
- Merge rule: only the addressed lane(s) are replaced; all other bytes keep their mem_rd value.
- Extension: byte uses bit 7 and half uses bit 15 when req_signed=1; req_signed is ignored for word loads and for stores.
- mem_we is 0 in every state except WRITE.
- Reset mid-RMW: the write is abandoned and memory is unchanged.
- req_valid deasserting in a non-IDLE state has no effect.

Optional Feature:
- MAU_BOUNDS_CHECK_EN defined: a request with req_addr + size_bytes > MEM_BYTES takes the ERR path and makes no memory access.
- Undefined: no range check; the address is passed through unchanged.

Decomposition:
- Package mau_pkg: state enum (IDLE, LOAD, RMW_RD, WRITE, RESP, ERR); size enum (SZ_B, SZ_H, SZ_W, SZ_RSV).
- Sub-module mau_lane_logic (combinational):
  - Store merge: old word, wdata, size, lane -> merged word.
  - Load extraction/extension: word, size, lane, signed -> result.

Test Plan:
- Word store 0x0000AFAF @0, then word load @0 -> one mem_we pulse at 0x0; load resp_rdata=0x0000AFAF, resp_err=0.
- Memory word @10000 = 0xFFFF0000; byte store 0xAB @10001 -> RMW writes 0xFFFFAB00; signed byte load @10001 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Word @152100 = 0xABCDEFAA; signed half load @152102 -> 0xFFFFABCD; unsigned half load @152100 -> 0x0000EFAA.
- Word load @2, half load @1, size 11 @0 -> each gives resp_err=1, resp_rdata=0, one cycle after accept, with no mem_we.
- rst_n low during RMW_RD of a byte store @0 (word 0x11223344) -> outputs reset immediately; memory stays 0x11223344.
- With MAU_BOUNDS_CHECK_EN, word store @262144 -> resp_err=1, no mem_we; without it, mem_we asserted with mem_addr=262144.
